// File: rtl/a2_timer.sv
// a2_timer -- AGC timing source feeding the scaler.
//
// A fractional phase accumulator running on SIM_CLK produces the emulated
// 2.048 MHz oscillator tick. Each tick toggles CLK (1.024 MHz). Every tick
// that takes CLK from 0 to 1 advances the twelve-slot time-pulse ring
// T01_..T12_. A separate divider produces FS01_ at tick/(2*FS_DIV), which
// feeds the scaler. Everything is synchronous to SIM_CLK. No derived clock
// is used as a clock.
//
// Optional feature, enabled by defining TIMER_MSTP_EN:
//   Adds the MSTP input (monitor stop). While MSTP=1 the ring parks on T12
//   when it gets there. CLK, FS01_ and OSCTICK keep running. MSTP is used
//   as-is; the caller must synchronise it.
//
// Ports:
//   SIM_CLK     in   system clock, rising-edge active
//   RESET_      in   asynchronous reset, active low
//   MSTP        in   monitor stop, active high (TIMER_MSTP_EN builds only)
//   CLK         out  1.024 MHz square wave
//   T01_..T12_  out  time pulses, active low, exactly one low at any time
//   FS01_       out  51.2 kHz square wave to the scaler, active low
//   OSCTICK     out  one-SIM_CLK-wide strobe per oscillator tick
//   ring_state  out  debug view of the ring FSM state (0 = T01 .. 11 = T12)
//
// All outputs come straight from flops, so none of them can glitch.

module a2_timer #(
  parameter int unsigned SIM_CLK_HZ = 50000000,
  parameter int unsigned OSC_HZ     = 2048000,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FS_DIV     = 20
) (
  input  logic       SIM_CLK,
  input  logic       RESET_,
`ifdef TIMER_MSTP_EN
  input  logic       MSTP,
`endif
  output logic       CLK,
  output logic       T01_,
  output logic       T02_,
  output logic       T03_,
  output logic       T04_,
  output logic       T05_,
  output logic       T06_,
  output logic       T07_,
  output logic       T08_,
  output logic       T09_,
  output logic       T10_,
  output logic       T11_,
  output logic       T12_,
  output logic       FS01_,
  output logic       OSCTICK,
  output logic [3:0] ring_state
);

  // Phase increment: floor(OSC_HZ * 2^ACC_W / SIM_CLK_HZ), worked out in 64 bits.
  localparam longint unsigned INC_L =
    (64'(OSC_HZ) << ACC_W) / 64'(SIM_CLK_HZ);
  localparam logic [ACC_W-1:0] INC = INC_L[ACC_W-1:0];

  // An increment of half the accumulator range or more would alias the tick
  // rate, so the build refuses it.
  generate
    if (INC_L >= (64'd1 << (ACC_W - 1))) begin : g_inc_check
      $error("a2_timer: INC must be below 2^(ACC_W-1); raise SIM_CLK_HZ or lower OSC_HZ");
    end
  endgenerate

  localparam int unsigned FS_W = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam logic [FS_W-1:0] FS_LAST = FS_W'(FS_DIV - 1);

  typedef enum logic [3:0] {
    S_T01 = 4'd0,  S_T02 = 4'd1,  S_T03 = 4'd2,  S_T04 = 4'd3,
    S_T05 = 4'd4,  S_T06 = 4'd5,  S_T07 = 4'd6,  S_T08 = 4'd7,
    S_T09 = 4'd8,  S_T10 = 4'd9,  S_T11 = 4'd10, S_T12 = 4'd11
  } ring_e;

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             tick;
  logic             advance;
  logic             hold;
  logic [FS_W-1:0]  fs_cnt;
  logic [11:0]      t_n;
  ring_e            ring_q;
  ring_e            ring_next;

  // The carry out of the accumulator is the oscillator tick for this cycle.
  assign acc_sum = {1'b0, acc} + {1'b0, INC};
  assign tick    = acc_sum[ACC_W];

  // The ring moves on the tick that raises CLK, which is every second tick.
  assign advance = tick & ~CLK;

`ifdef TIMER_MSTP_EN
  assign hold = MSTP;
`else
  assign hold = 1'b0;
`endif

  // Ring next state. Leaving T12 is the only move that MSTP can block, so a
  // stop requested mid-MCT still finishes the MCT before parking.
  always_comb begin
    ring_next = ring_q;
    if (advance) begin
      if (ring_q == S_T12) begin
        ring_next = hold ? S_T12 : S_T01;
      end else begin
        ring_next = ring_e'(ring_q + 4'd1);
      end
    end
  end

  // Ring state and its one-hot-low pulse register. The pulse register loads
  // from ring_next, so the pulses change on the same edge as the state.
  always_ff @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) begin
      ring_q <= S_T12;
      t_n    <= 12'h7FF;
    end else begin
      ring_q <= ring_next;
      t_n    <= ~(12'd1 << ring_next);
    end
  end

  // Accumulator, tick strobe, CLK and the FS01_ divider.
  always_ff @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) begin
      acc     <= '0;
      OSCTICK <= 1'b0;
      CLK     <= 1'b0;
      fs_cnt  <= '0;
      FS01_   <= 1'b1;
    end else begin
      acc     <= acc_sum[ACC_W-1:0];
      OSCTICK <= tick;
      if (tick) begin
        CLK <= ~CLK;
        if (fs_cnt == FS_LAST) begin
          fs_cnt <= '0;
          FS01_  <= ~FS01_;
        end else begin
          fs_cnt <= fs_cnt + 1'b1;
        end
      end
    end
  end

  assign ring_state = ring_q;

  assign T01_ = t_n[0];
  assign T02_ = t_n[1];
  assign T03_ = t_n[2];
  assign T04_ = t_n[3];
  assign T05_ = t_n[4];
  assign T06_ = t_n[5];
  assign T07_ = t_n[6];
  assign T08_ = t_n[7];
  assign T09_ = t_n[8];
  assign T10_ = t_n[9];
  assign T11_ = t_n[10];
  assign T12_ = t_n[11];

endmodule

// File: tb/tb_a2_timer.sv
// Bench for a2_timer with two instances on one clock.
//   d_*: default parameters (50 MHz SIM_CLK). Used for the rate check and for
//        ring integrity.
//   x_*: SIM_CLK_HZ=8192000, which gives INC = 2^30 exactly. Here a tick
//        lands on every 4th edge, so CLK has a period of 8 cycles, each pulse
//        is 8 cycles wide, FS01_ has a period of 160 cycles, and the first
//        FS01_ fall is at edge 80. A 2:1 ratio would need INC = 2^31, which
//        the design rejects at elaboration.
// Edge numbers count SIM_CLK rising edges after RESET_ is released.

module tb_a2_timer;

  logic SIM_CLK = 1'b0;
  logic RESET_;
  logic mon_en;
`ifdef TIMER_MSTP_EN
  logic mstp;
`endif

  logic        d_clk, d_fs, d_tick;
  logic [11:0] d_t;
  logic [3:0]  d_ring;
  logic        x_clk, x_fs, x_tick;
  logic [11:0] x_t;
  logic [3:0]  x_ring;

  int n_checks = 0;
  int n_err    = 0;
  int cyc;

  a2_timer dut_d (
    .SIM_CLK(SIM_CLK), .RESET_(RESET_),
`ifdef TIMER_MSTP_EN
    .MSTP(1'b0),
`endif
    .CLK(d_clk),
    .T01_(d_t[0]), .T02_(d_t[1]), .T03_(d_t[2]), .T04_(d_t[3]),
    .T05_(d_t[4]), .T06_(d_t[5]), .T07_(d_t[6]), .T08_(d_t[7]),
    .T09_(d_t[8]), .T10_(d_t[9]), .T11_(d_t[10]), .T12_(d_t[11]),
    .FS01_(d_fs), .OSCTICK(d_tick), .ring_state(d_ring)
  );

  a2_timer #(.SIM_CLK_HZ(8192000)) dut_x (
    .SIM_CLK(SIM_CLK), .RESET_(RESET_),
`ifdef TIMER_MSTP_EN
    .MSTP(mstp),
`endif
    .CLK(x_clk),
    .T01_(x_t[0]), .T02_(x_t[1]), .T03_(x_t[2]), .T04_(x_t[3]),
    .T05_(x_t[4]), .T06_(x_t[5]), .T07_(x_t[6]), .T08_(x_t[7]),
    .T09_(x_t[8]), .T10_(x_t[9]), .T11_(x_t[10]), .T12_(x_t[11]),
    .FS01_(x_fs), .OSCTICK(x_tick), .ring_state(x_ring)
  );

  // ---------------- clock / reset ----------------
  always #5 SIM_CLK = ~SIM_CLK;

  always @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  function automatic int low_idx(input logic [11:0] t);
    int idx = -1;
    int n   = 0;
    for (int i = 0; i < 12; i++) begin
      if (t[i] == 1'b0) begin
        idx = i;
        n++;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  // Ring monitor step: one pulse low, next pulse in order, each pulse 2 ticks wide.
  task automatic ring_mon(input logic [11:0] t, input logic tk_in, inout int prev,
                          inout bit first, inout int tks, inout int viol, inout int mcts);
    int cur;
    cur = low_idx(t);
    if (tk_in) tks++;
    if (cur < 0) begin
      viol++;
    end else if (cur != prev) begin
      if (cur != (prev + 1) % 12) viol++;
      if (!first && tks != 2) viol++;
      if (cur == 0) mcts++;
      first = 1'b0;
      tks   = 0;
      prev  = cur;
    end
  endtask

  // ---------------- monitors ----------------
  int xp, xk, x_viol = 0, x_mcts = 0;
  int dp, dk, d_viol = 0, d_mcts = 0;
  bit xf, df;
  int d_ticks = 0, d_rises = 0, d_falls = 0;
  logic d_clk_prev = 1'b0, d_fs_prev = 1'b1, x_fs_prev = 1'b1;
  int x_last_fall = 0, x_fs_viol = 0;

  initial forever begin
    @(negedge SIM_CLK);
    if (!RESET_ || !mon_en) begin
      xp = low_idx(x_t); xf = 1'b1; xk = 0;
      dp = low_idx(d_t); df = 1'b1; dk = 0;
    end else begin
      ring_mon(x_t, x_tick, xp, xf, xk, x_viol, x_mcts);
      ring_mon(d_t, d_tick, dp, df, dk, d_viol, d_mcts);
    end
    if (RESET_ && cyc >= 1 && cyc <= 40000) begin
      if (d_tick) d_ticks++;
      if (d_clk && !d_clk_prev) d_rises++;
      if (!d_fs && d_fs_prev) d_falls++;
    end
    if (!RESET_) begin
      x_last_fall = 0;
    end else if (!x_fs && x_fs_prev) begin
      if (x_last_fall == 0) begin
        if (cyc != 80) x_fs_viol++;
      end else if (cyc - x_last_fall != 160) begin
        x_fs_viol++;
      end
      x_last_fall = cyc;
    end
    d_clk_prev = d_clk;
    d_fs_prev  = d_fs;
    x_fs_prev  = x_fs;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    while (cyc < n) @(negedge SIM_CLK);
  endtask

  task automatic wait_low(input int idx, input int budget, input string tag);
    int k = 0;
    while (x_t[idx] !== 1'b0 && k < budget) begin
      @(negedge SIM_CLK);
      k++;
    end
    check(tag, {31'd0, x_t[idx]}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x_clk"}, x_clk, 0);
    check({tag, "_x_fs"}, x_fs, 1);
    check({tag, "_x_tick"}, x_tick, 0);
    check({tag, "_x_t"}, x_t, 12'h7FF);
    check({tag, "_d_clk"}, d_clk, 0);
    check({tag, "_d_fs"}, d_fs, 1);
    check({tag, "_d_tick"}, d_tick, 0);
    check({tag, "_d_t"}, d_t, 12'h7FF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET_ = 1'b0;
    mon_en = 1'b1;
`ifdef TIMER_MSTP_EN
    mstp = 1'b0;
`endif
    repeat (3) @(negedge SIM_CLK);
    check_reset_state("rst");
    check("rst_x_ring", x_ring, 11);
    check("rst_d_ring", d_ring, 11);
    RESET_ = 1'b1;

    // Exact-divide instance: ticks land on edges 4, 8, 12, ...
    step(3);   check("x3_tick", x_tick, 0); check("x3_clk", x_clk, 0); check("x3_t", x_t, 12'h7FF);
    step(4);   check("x4_tick", x_tick, 1); check("x4_clk", x_clk, 1);
               check("x4_t01", x_t, 12'hFFE); check("x4_ring", x_ring, 0);
    step(5);   check("x5_tick", x_tick, 0); check("x5_clk", x_clk, 1);
    step(8);   check("x8_tick", x_tick, 1); check("x8_clk", x_clk, 0); check("x8_t01", x_t, 12'hFFE);
    step(12);  check("x12_t02", x_t, 12'hFFD); check("x12_clk", x_clk, 1);
    // Default instance: first carry on edge 25 (24*INC < 2^32 <= 25*INC).
    step(24);  check("d24_tick", d_tick, 0); check("d24_clk", d_clk, 0); check("d24_t", d_t, 12'h7FF);
    step(25);  check("d25_tick", d_tick, 1); check("d25_clk", d_clk, 1); check("d25_t01", d_t, 12'hFFE);
    step(79);  check("x79_fs", x_fs, 1);
    step(80);  check("x80_fs_fall", x_fs, 0);
    step(92);  check("x92_t12", x_t, 12'h7FF);
    step(100); check("x100_t01", x_t, 12'hFFE);
    step(159); check("x159_fs", x_fs, 0);
    step(160); check("x160_fs_rise", x_fs, 1);

    // Rate at defaults over 40000 edges: floor(40000*INC/2^32) = 1638 ticks,
    // CLK rises on odd ticks (819), FS01_ falls on ticks 20, 60, .. 1620 (41).
    step(40001);
    check("d_tick_count", d_ticks, 1638);
    check("d_clk_rises", d_rises, 819);
    check("d_fs_falls", d_falls, 41);

`ifdef TIMER_MSTP_EN
    begin
      int hold_viol = 0;
      int k = 0;
      wait_low(4, 200, "mstp_find_t05");
      mon_en = 1'b0;
      mstp = 1'b1;
      wait_low(11, 200, "mstp_reach_t12");
      repeat (400) begin
        @(negedge SIM_CLK);
        if (x_t !== 12'h7FF) hold_viol++;
      end
      check("mstp_hold_t12", hold_viol, 0);
      mstp = 1'b0;
      @(negedge SIM_CLK);
      while (!(x_clk && x_tick) && k < 20) begin
        @(negedge SIM_CLK);
        k++;
      end
      check("mstp_release_t01", x_t, 12'hFFE);
      mon_en = 1'b1;
    end
`endif

    step(cyc + 200);
    check("x_ring_viol", x_viol, 0);
    check("d_ring_viol", d_viol, 0);
    check("x_mcts_ge100", {31'd0, x_mcts >= 100}, 1);
    check("d_mcts_ge50", {31'd0, d_mcts >= 50}, 1);
    check("x_fs_viol", x_fs_viol, 0);

    // Reset in the middle of a cycle while the ring sits on T07.
    wait_low(6, 200, "find_t07");
    @(posedge SIM_CLK);
    #3;
    RESET_ = 1'b0;
    #1;
    check_reset_state("midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
